// File: rtl/cpu_commit_pkg.sv
// rtl/cpu_commit_pkg.sv - shared encodings for the commit stage
package cpu_commit_pkg;

    localparam int WORD_W    = 32;
    localparam int STACK_W   = 35;
    localparam int POP_CNT_W = 11;
    localparam int INSTR_W   = 48;

    // Branch class carried by the 3a bundle
    localparam logic [1:0] UC_BRANCH_NONE     = 2'd0;
    localparam logic [1:0] UC_BRANCH_COND     = 2'd1;
    localparam logic [1:0] UC_BRANCH_JUMP     = 2'd2;
    localparam logic [1:0] UC_BRANCH_INDIRECT = 2'd3;

    // Bit positions inside the push mask; also the push order
    localparam int UC_PUSH_ALU_BIT = 0;
    localparam int UC_PUSH_R0_BIT  = 1;
    localparam int UC_PUSH_R1_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POP      = 3'd1,
        ST_PUSH_ALU = 3'd2,
        ST_PUSH_R0  = 3'd3,
        ST_PUSH_R1  = 3'd4
    } commit_state_t;

endpackage

// File: rtl/cpu_commit.sv
// rtl/cpu_commit.sv - branch resolution and stack-op sequencing after execute
module cpu_commit
    import cpu_commit_pkg::*;
#(
    parameter int KILL_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 alu__cond_3a,
    input  logic [WORD_W-1:0]    alu__out_3a,
    input  logic [1:0]           c__branch_3a,
    input  logic [2:0]           c__to_push_3a,
    input  logic [INSTR_W-1:0]   instruction_3a,
    input  logic [WORD_W-1:0]    pc_3a,
    input  logic [STACK_W-1:0]   r0_3a,
    input  logic [STACK_W-1:0]   r1_3a,
    input  logic [POP_CNT_W-1:0] st__to_pop_3a,
    input  logic                 st__ready_4a,
    output logic                 st__pop_valid_4a,
    output logic [POP_CNT_W-1:0] st__pop_count_4a,
    output logic                 st__push_valid_4a,
    output logic [STACK_W-1:0]   st__push_data_4a,
    output logic                 pc_redirect_valid_4a,
    output logic [WORD_W-1:0]    pc_redirect_4a,
    output logic                 kill_4a,
    output logic                 stall_4a
);

    commit_state_t state, state_nxt;

    logic [POP_CNT_W-1:0] pop_cnt_q;
    logic [2:0]           push_mask_q;
    logic [STACK_W-1:0]   r0_q;
    logic [STACK_W-1:0]   r1_q;
    logic [WORD_W-1:0]    alu_q;

    logic                 kill_q;
    logic [CNT_W-1:0]     kill_cnt_q;
    logic                 redirect_valid_q;
    logic [WORD_W-1:0]    redirect_q;

    logic                 capture;
    logic                 taken;
    logic [WORD_W-1:0]    target;

    // pc and the upper instruction bits are carried for debug only
    logic unused_bundle_bits;
    assign unused_bundle_bits = ^{pc_3a, instruction_3a[INSTR_W-1:WORD_W]};

    // First push state for a mask, honouring the fixed ALU, R0, R1 order
    function automatic commit_state_t first_push(input logic [2:0] mask);
        commit_state_t s;
        if (mask[UC_PUSH_ALU_BIT])
            s = ST_PUSH_ALU;
        else if (mask[UC_PUSH_R0_BIT])
            s = ST_PUSH_R0;
        else if (mask[UC_PUSH_R1_BIT])
            s = ST_PUSH_R1;
        else
            s = ST_IDLE;
        return s;
    endfunction

    // A bundle is taken in only while idle and not inside a kill window
    assign capture = (state == ST_IDLE) && !kill_q;

    // Branch decision and target for the bundle sitting at 3a
    always_comb begin
        taken  = 1'b0;
        target = instruction_3a[WORD_W-1:0];
        case (c__branch_3a)
            UC_BRANCH_COND:     taken = alu__cond_3a;
            UC_BRANCH_JUMP:     taken = 1'b1;
            UC_BRANCH_INDIRECT: begin
                taken  = 1'b1;
                target = alu__out_3a;
            end
            default:            taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and stack-unit request decode
    always_comb begin
        state_nxt         = state;
        st__pop_valid_4a  = 1'b0;
        st__push_valid_4a = 1'b0;
        st__push_data_4a  = '0;
        stall_4a          = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    if (st__to_pop_3a != '0)
                        state_nxt = ST_POP;
                    else
                        state_nxt = first_push(c__to_push_3a);
                end
            end
            ST_POP: begin
                st__pop_valid_4a = 1'b1;
                if (st__ready_4a)
                    state_nxt = first_push(push_mask_q);
            end
            ST_PUSH_ALU: begin
                st__push_valid_4a = 1'b1;
                st__push_data_4a  = {3'b000, alu_q};
                if (st__ready_4a)
                    state_nxt = first_push(push_mask_q & 3'b110);
            end
            ST_PUSH_R0: begin
                st__push_valid_4a = 1'b1;
                st__push_data_4a  = r0_q;
                if (st__ready_4a)
                    state_nxt = first_push(push_mask_q & 3'b100);
            end
            ST_PUSH_R1: begin
                st__push_valid_4a = 1'b1;
                st__push_data_4a  = r1_q;
                if (st__ready_4a)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign st__pop_count_4a = pop_cnt_q;

    // Holding registers keep the captured operands stable across the sequence
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pop_cnt_q   <= '0;
            push_mask_q <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            alu_q       <= '0;
        end else if (capture) begin
            pop_cnt_q   <= st__to_pop_3a;
            push_mask_q <= c__to_push_3a;
            r0_q        <= r0_3a;
            r1_q        <= r1_3a;
            alu_q       <= alu__out_3a;
        end
    end

    // Kill window counts discarded captures, so stalls do not shorten it
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            kill_q     <= 1'b0;
            kill_cnt_q <= '0;
        end else if (capture && taken) begin
            kill_q     <= 1'b1;
            kill_cnt_q <= KILL_DEPTH[CNT_W-1:0];
        end else if ((state == ST_IDLE) && kill_q) begin
            kill_cnt_q <= kill_cnt_q - 1'b1;
            if (kill_cnt_q == CNT_W'(1))
                kill_q <= 1'b0;
        end
    end

    // One-cycle redirect strobe following a taken branch capture
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            redirect_valid_q <= 1'b0;
            redirect_q       <= '0;
        end else begin
            redirect_valid_q <= capture && taken;
            if (capture && taken)
                redirect_q <= target;
        end
    end

    assign kill_4a              = kill_q;
    assign pc_redirect_valid_4a = redirect_valid_q;
    assign pc_redirect_4a       = redirect_q;

endmodule
